// File: rtl/freq_cmd_pkg.sv
// freq_cmd_pkg: shared state encoding, bin sentinel and default tuning for the mic command voter.
package freq_cmd_pkg;
    typedef enum logic [1:0] {IDLE, LISTEN, LOCKED} state_t;
    localparam int BIN_W = 8;
    localparam logic [BIN_W-1:0] BIN_NONE = '1;
    localparam logic [47:0] DEF_CENTERS = {16'd375, 16'd250, 16'd125};
    localparam int DEF_TOL = 10;
endpackage

// File: rtl/freq_cmd_voter_if.sv
// freq_cmd_voter_if: control inputs and command/status outputs of the mic command voter.
interface freq_cmd_voter_if #(
    parameter int NUM_BINS = 3,
    parameter int CNT_W    = 16
);
    logic                enable;
    logic                mic;
    logic [NUM_BINS-1:0] command;
    logic                cmd_valid;
    logic                mic_en;
    logic                busy;
    logic [CNT_W-1:0]    last_count;
    modport master (output enable, mic, input command, cmd_valid, mic_en, busy, last_count);
    modport slave  (input enable, mic, output command, cmd_valid, mic_en, busy, last_count);
endinterface

// File: rtl/freq_cmd_voter_wave_window_counter.sv
// freq_cmd_voter_wave_window_counter: synchronised mic rising-edge counter over fixed windows.
module freq_cmd_voter_wave_window_counter #(
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mic,
    output logic [CNT_W-1:0] count,
    output logic             window_done
);
    localparam int WW = WINDOW_CYCLES > 1 ? $clog2(WINDOW_CYCLES) : 1;
    logic [1:0]       sync;
    logic [WW-1:0]    wcnt;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    assign rise        = sync[0] & ~sync[1];
    // count includes an edge landing on the closing cycle of the window
    assign count       = (rise && !(&cnt)) ? cnt + 1'b1 : cnt;
    assign window_done = run && wcnt == WW'(WINDOW_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            wcnt <= '0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], mic};
            wcnt <= (!run || window_done) ? '0 : wcnt + 1'b1;
            cnt  <= (!run || window_done) ? '0 : count;
        end
    end
endmodule

// File: rtl/freq_cmd_voter.sv
// freq_cmd_voter: classifies mic edge counts per window into bins and locks a one-hot command after VOTES agreeing windows.
module freq_cmd_voter
    import freq_cmd_pkg::*;
#(
    parameter int                          WINDOW_CYCLES = 25_000_000,
    parameter int                          CNT_W         = 16,
    parameter int                          NUM_BINS      = 3,
    parameter logic [NUM_BINS*CNT_W-1:0]   BIN_CENTERS   = DEF_CENTERS,
    parameter int                          TOL           = DEF_TOL,
    parameter int                          VOTES         = 8,
    parameter logic [NUM_BINS-1:0]         HOLD_MASK     = 3'b100
) (
    input logic            clk,
    input logic            rst,
    freq_cmd_voter_if.slave bus
);
    localparam int SW = $clog2(VOTES + 1);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W + 1)'(TOL);
    state_t              state, nxt_state;
    logic                run, done, hit;
    logic [CNT_W-1:0]    total;
    logic [BIN_W-1:0]    bin, prev_bin;
    logic [NUM_BINS-1:0] oh, nxt_cmd;
    logic [SW-1:0]       streak, nxt_streak;
    function automatic logic [BIN_W-1:0] classify(input logic [CNT_W-1:0] c);
        logic signed [CNT_W:0] d;
        classify = BIN_NONE;
        for (int i = NUM_BINS - 1; i >= 0; i--) begin
            d = $signed({1'b0, c}) - $signed({1'b0, BIN_CENTERS[i*CNT_W +: CNT_W]});
            if ((d[CNT_W] ? -d : d) <= TOL_S) classify = BIN_W'(i);
        end
    endfunction
    function automatic logic [NUM_BINS-1:0] onehot(input logic [BIN_W-1:0] b);
        for (int i = 0; i < NUM_BINS; i++) onehot[i] = b == BIN_W'(i);
    endfunction
    freq_cmd_voter_wave_window_counter #(.WINDOW_CYCLES(WINDOW_CYCLES), .CNT_W(CNT_W)) u_win (
        .clk(clk), .rst(rst), .run(run), .mic(bus.mic), .count(total), .window_done(done)
    );
    // command is one-hot of the locked bin, so it doubles as the hold-mask selector
    assign run = bus.enable && (state == LISTEN || (state == LOCKED && |(HOLD_MASK & bus.command)));
    always_comb begin
        bin        = classify(total);
        oh         = onehot(bin);
        nxt_streak = bin == BIN_NONE ? '0 :
                     bin != prev_bin ? SW'(1) :
                     streak == SW'(VOTES) ? streak : streak + 1'b1;
        hit        = done && nxt_streak == SW'(VOTES) && oh != bus.command;
        nxt_state  = !bus.enable ? IDLE : state == IDLE ? LISTEN : hit ? LOCKED : state;
        nxt_cmd    = !bus.enable ? '0 : hit ? oh : bus.command;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.command    <= '0;
            bus.cmd_valid  <= 1'b0;
            bus.mic_en     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.last_count <= '0;
            prev_bin       <= BIN_NONE;
            streak         <= '0;
        end else begin
            bus.command    <= nxt_cmd;
            bus.cmd_valid  <= hit;
            bus.mic_en     <= nxt_state == LISTEN || (nxt_state == LOCKED && |(HOLD_MASK & nxt_cmd));
            bus.busy       <= nxt_state == LISTEN;
            bus.last_count <= done ? total : bus.last_count;
            prev_bin       <= !bus.enable ? BIN_NONE : done ? bin : prev_bin;
            streak         <= !bus.enable ? '0 : done ? nxt_streak : streak;
        end
    end
endmodule

// File: tb/tb_freq_cmd_voter.sv
// tb_freq_cmd_voter: directed checks of windowing, voting, locking, hold and clearing behaviour.
module tb_freq_cmd_voter;
    localparam int W = 1000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    freq_cmd_voter_if #(.NUM_BINS(3), .CNT_W(8)) bus ();
    freq_cmd_voter #(
        .WINDOW_CYCLES(W), .CNT_W(8), .NUM_BINS(3), .BIN_CENTERS({8'd15, 8'd10, 8'd5}),
        .TOL(1), .VOTES(4), .HOLD_MASK(3'b100)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.cmd_valid === 1'b1) pulses++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic pat(input int n, input int j, input bit late);
        return (j >= 10 && j < 10 + 2 * n && j % 2 == 0) || (late && j == W - 2);
    endfunction
    // drive one full window starting at its cycle 0 negedge; returns at cycle 0 of the next window
    task automatic win(input int n, input bit late = 1'b0);
        for (int j = 0; j < W; j++) begin
            bus.mic = pat(n, j, late);
            @(negedge clk);
        end
    endtask
    task automatic start();
        bus.enable = 1'b1;
        @(negedge clk);
    endtask
    task automatic stop();
        bus.enable = 1'b0;
        bus.mic    = 1'b0;
        repeat (2) @(negedge clk);
    endtask
    initial begin
        bus.enable = 1'b0;
        bus.mic    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        // reset mid-listen
        start();
        check("listen_busy", bus.busy, 1);
        check("listen_mic_en", bus.mic_en, 1);
        win(7);
        check("t1_last_count", bus.last_count, 7);
        for (int j = 0; j < 300; j++) begin
            bus.mic = j[0];
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("t1_rst_busy", bus.busy, 0);
        check("t1_rst_mic_en", bus.mic_en, 0);
        check("t1_rst_last_count", bus.last_count, 0);
        check("t1_rst_command", bus.command, 0);
        bus.enable = 1'b0;
        bus.mic    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_hold_busy", bus.busy, 0);
        check("t1_hold_mic_en", bus.mic_en, 0);
        // 10 edges x4 -> bin1, no hold
        start();
        repeat (3) win(10);
        check("t2_no_lock_yet", bus.command, 0);
        win(10);
        check("t2_command", bus.command, 3'b010);
        check("t2_cmd_valid", bus.cmd_valid, 1);
        check("t2_last_count", bus.last_count, 10);
        check("t2_mic_en", bus.mic_en, 0);
        @(negedge clk);
        check("t2_pulse_end", bus.cmd_valid, 0);
        check("t2_pulses", pulses, 1);
        win(15);
        check("t2_no_more_windows", bus.last_count, 10);
        check("t2_cmd_held", bus.command, 3'b010);
        stop();
        // 5,5,5,11 then 5 x4
        start();
        win(5); win(5); win(5); win(11);
        check("t3_broken_streak", bus.command, 0);
        check("t3_last_count", bus.last_count, 11);
        repeat (3) win(5);
        check("t3_no_lock_7", bus.command, 0);
        win(5);
        check("t3_command", bus.command, 3'b001);
        check("t3_cmd_valid", bus.cmd_valid, 1);
        @(negedge clk);
        check("t3_pulses", pulses, 2);
        stop();
        // 15 x4 (hold), re-lock on same bin, NONE windows, then 10 x4
        start();
        repeat (4) win(15);
        check("t4_command_hold", bus.command, 3'b100);
        check("t4_cmd_valid", bus.cmd_valid, 1);
        check("t4_mic_en_hold", bus.mic_en, 1);
        check("t4_busy_locked", bus.busy, 0);
        win(15);
        check("t4_same_bin_no_pulse", bus.cmd_valid, 0);
        repeat (2) win(0);
        check("t4_none_keeps_cmd", bus.command, 3'b100);
        check("t4_none_last_count", bus.last_count, 0);
        repeat (3) win(10);
        check("t4_switch_pending", bus.command, 3'b100);
        win(10);
        check("t4_command_switch", bus.command, 3'b010);
        check("t4_cmd_valid2", bus.cmd_valid, 1);
        @(negedge clk);
        check("t4_pulses", pulses, 4);
        check("t4_mic_en_off", bus.mic_en, 0);
        repeat (6) win(0);
        check("t4_cmd_after_zero", bus.command, 3'b010);
        stop();
        // edge on final window cycle, then a 1-clk enable drop mid-window
        start();
        win(9, 1'b1);
        check("t5_edge_on_last_cycle", bus.last_count, 10);
        win(10);
        for (int j = 0; j < 500; j++) begin
            bus.mic = pat(10, j, 1'b0);
            @(negedge clk);
        end
        bus.enable = 1'b0;
        bus.mic    = 1'b0;
        @(negedge clk);
        check("t5_disabled_busy", bus.busy, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        repeat (3) win(10);
        check("t5_streak_cleared", bus.command, 0);
        win(10);
        check("t5_command", bus.command, 3'b010);
        check("t5_cmd_valid", bus.cmd_valid, 1);
        stop();
        // saturated window breaks the streak
        start();
        repeat (3) win(5);
        win(300);
        check("t6_saturated", bus.last_count, 255);
        check("t6_no_cmd", bus.command, 0);
        repeat (3) win(5);
        check("t6_streak_reset", bus.command, 0);
        win(5);
        check("t6_command", bus.command, 3'b001);
        @(negedge clk);
        check("t6_pulses", pulses, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
